merger_leaf_feeder: RTL
=======================

// Module: merger_leaf_feeder
// PURPOSE
// - Source side of the merger input interface: converts one record stream into two terminated
//   sorted-run lanes for a 2-to-1 merger leaf.
// - Upstream supplies records already sorted within runs of RUN_LEN.
// - Run k goes to lane (k mod 2); each run is closed by an all-zero terminator record.
// - Each lane is exposed as a show-ahead FIFO port: data / empty / read.
// PARAMETERS
// - DATA_WIDTH  128  record width; all-zero record is reserved as run terminator
// - KEY_WIDTH   80   key field [KEY_WIDTH-1:0]; carried only, never compared
// - RUN_LEN     16   records per run (>=1) before a terminator is forced
// - DEPTH       4    entries per lane FIFO, power of 2, >=2
// PORTS
// - i_clk            in   1           clock, rising edge
// - i_rst_n          in   1           async active-low reset
// - i_data           in   DATA_WIDTH  upstream record
// - i_valid          in   1           i_data valid
// - i_last           in   1           i_data is the final record of the stream (ends run early)
// - o_ready          out  1           record accepted when i_valid & o_ready
// - o_fifo_1         out  DATA_WIDTH  lane-1 head record
// - o_fifo_1_empty   out  1           lane-1 empty
// - i_fifo_1_read    in   1           pop lane-1 head this cycle
// - o_fifo_2         out  DATA_WIDTH  lane-2 head record
// - o_fifo_2_empty   out  1           lane-2 empty
// - i_fifo_2_read    in   1           pop lane-2 head this cycle
// - o_err            out  1           sticky: zero input record dropped, or read while empty
// BEHAVIOUR
// - Reset (async, while low):
//   - FSM=FILL_1, run_cnt=0, both FIFOs cleared.
//   - o_fifo_N=0, o_fifo_N_empty=1, o_ready=0, o_err=0.
//   - Mid-operation reset discards all buffered records and terminators.
// - FSM states: FILL_1, TERM_1, FILL_2, TERM_2.
//   - FILL_N: o_ready = ~laneN_full. Accepted record enqueued to lane N; run_cnt++.
//     - If run_cnt reaches RUN_LEN or i_last: go to TERM_N, run_cnt=0.
//     - If i_last in FILL_1: set flag last_pend.
//   - TERM_N: o_ready=0. When ~laneN_full, enqueue all-zero record.
//     - TERM_1 -> FILL_2, except TERM_1 with last_pend -> TERM_2 (lane 2 gets an empty run,
//       i.e. a bare terminator, so the merger never stalls).
//     - TERM_2 -> FILL_1, clear last_pend.
//   - Terminator write is the only enqueue in a TERM cycle; one enqueue per lane per cycle max.
// - Zero input record (all DATA_WIDTH bits 0) accepted in FILL_N:
//   - Consumed (o_ready honoured), not enqueued, not counted; o_err<=1.
//   - If it carries i_last: run ends normally (TERM_N entered).
// - Lane FIFO: show-ahead.
//   - Write at edge t -> head visible and empty=0 from t+1 (latency 1, no bypass).
//   - Read with ~empty pops at edge; next entry visible same edge.
//   - Read while empty: ignored, o_err<=1.
//   - Simultaneous read+write legal at any occupancy except write-when-full, which the FSM never
//     issues: full is evaluated before the pop, so no same-cycle reuse of a freed slot.
//   - Pointers are log2(DEPTH)+1 bits and wrap; full = MSBs differ & low bits equal.
//   - o_fifo_N = 0 when empty.
// - o_ready is combinational from FSM state and the target lane's full flag only; it never
//   depends on i_valid.
// - Throughput: 1 record/cycle in FILL; each run costs 1 extra cycle (terminator).
// - run_cnt width clog2(RUN_LEN+1); never exceeds RUN_LEN.
// STRUCTURE
// - Shared package merger_pkg: DATA_WIDTH/KEY_WIDTH defaults, TERM_RECORD = '0,
//   feeder state enum {FILL_1, TERM_1, FILL_2, TERM_2}.
// - One sub-module: merger_lane_fifo (show-ahead FIFO, params DATA_WIDTH, DEPTH), instanced twice.
// - FSM, run counter, last_pend and error flag live in the top.
// TESTING
// - RUN_LEN=4, feed keys 1..8 continuously, both reads held high:
//   - lane1 yields 1,2,3,4,0; lane2 yields 5,6,7,8,0.
//   - o_ready low exactly 1 cycle after the 4th and after the 8th accept.
// - Reads held low, DEPTH=4, RUN_LEN=16:
//   - o_ready drops after 4 accepts, lane1 full.
//   - Raise i_fifo_1_read one cycle: o_ready returns the following cycle; no record lost or
//     duplicated.
// - i_last on 2nd record (keys 10,11):
//   - lane1 = 10,11,0; lane2 = lone 0.
//   - Next record (key 20) lands in lane1.
// - Zero record injected mid-run between keys 3 and 4:
//   - Dropped, o_err=1 and stays 1.
//   - Run still contains RUN_LEN nonzero records.
// - i_fifo_2_read pulsed while lane2 empty: lane state unchanged, o_err=1.
// - i_rst_n pulsed low mid-run with 3 records buffered:
//   - Immediately both empty=1, o_ready=0, data=0.
//   - After release, first record goes to lane1 with run_cnt=0.

Source files
------------

// File: rtl/merger_pkg.sv
// rtl/merger_pkg.sv - shared defaults, terminator record and feeder state type for the merger front end
//
// Exports:
//   MERGER_DATA_WIDTH  default record width
//   MERGER_KEY_WIDTH   default key field width (low bits of a record)
//   TERM_RECORD        all-zero record that closes a sorted run
//   feeder_state_t     lane feeder FSM states
package merger_pkg;

    localparam int MERGER_DATA_WIDTH = 128;
    localparam int MERGER_KEY_WIDTH  = 80;

    localparam logic [MERGER_DATA_WIDTH-1:0] TERM_RECORD = '0;

    typedef enum logic [1:0] {
        FILL_1 = 2'd0,
        TERM_1 = 2'd1,
        FILL_2 = 2'd2,
        TERM_2 = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/merger_lane_fifo.sv
// rtl/merger_lane_fifo.sv - show-ahead lane FIFO feeding one merger leaf input
//
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset (clears pointers)
//   i_wr, i_wdata   enqueue request and record (ignored when full)
//   i_rd            pop head (ignored when empty)
//   o_rdata         head record, forced to 0 when empty
//   o_empty, o_full occupancy flags, both from registered pointers
//   o_rd_err        combinational pulse: read requested while empty
module merger_lane_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_rd_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic                  do_wr;
    logic                  do_rd;

    // Extra pointer MSB tells a full ring from an empty one.
    assign o_empty  = (wptr == rptr);
    assign o_full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_wr    = i_wr & ~o_full;
    assign do_rd    = i_rd & ~o_empty;
    assign o_rd_err = i_rd & o_empty;

    // Head is read straight from storage; no write-to-read bypass, so a new
    // record shows up the cycle after it is written.
    assign o_rdata  = o_empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + PW'(1);
            if (do_rd) rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/merger_leaf_feeder.sv
// rtl/merger_leaf_feeder.sv - splits a run-sorted record stream into two terminated lanes for a 2-to-1 merger leaf
//
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_data, i_valid, i_last, o_ready upstream record stream (accept = i_valid & o_ready)
//   o_fifo_1, o_fifo_1_empty, i_fifo_1_read  lane-1 show-ahead FIFO port
//   o_fifo_2, o_fifo_2_empty, i_fifo_2_read  lane-2 show-ahead FIFO port
//   o_err                           sticky: zero record dropped or lane read while empty
module merger_leaf_feeder
    import merger_pkg::*;
#(
    parameter int DATA_WIDTH = MERGER_DATA_WIDTH,
    parameter int KEY_WIDTH  = MERGER_KEY_WIDTH,
    parameter int RUN_LEN    = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_fifo_1,
    output logic                  o_fifo_1_empty,
    input  logic                  i_fifo_1_read,
    output logic [DATA_WIDTH-1:0] o_fifo_2,
    output logic                  o_fifo_2_empty,
    input  logic                  i_fifo_2_read,
    output logic                  o_err
);

    localparam int CW = $clog2(RUN_LEN + 1);
    localparam logic [DATA_WIDTH-1:0] TERM = DATA_WIDTH'(TERM_RECORD);

    feeder_state_t         state;
    logic [CW-1:0]         run_cnt;
    logic                  last_pend;
    logic                  active;
    logic                  err;

    logic                  full_1;
    logic                  full_2;
    logic                  rd_err_1;
    logic                  rd_err_2;
    logic                  wr_1;
    logic                  wr_2;
    logic [DATA_WIDTH-1:0] wdata_1;
    logic [DATA_WIDTH-1:0] wdata_2;
    logic                  is_zero;
    logic                  accept;
    logic                  run_end;

    // Key and payload checked separately; together they cover the whole record.
    assign is_zero = (i_data[KEY_WIDTH-1:0] == '0) && (i_data[DATA_WIDTH-1:KEY_WIDTH] == '0);
    assign accept  = i_valid & o_ready;

    // Zero records are consumed without counting, so only real records can
    // complete a run; i_last closes it regardless.
    assign run_end = accept & (i_last | (~is_zero & (run_cnt == CW'(RUN_LEN - 1))));

    // active holds o_ready low through reset and the first cycle after it.
    always_comb begin
        o_ready = 1'b0;
        case (state)
            FILL_1:  o_ready = active & ~full_1;
            FILL_2:  o_ready = active & ~full_2;
            default: o_ready = 1'b0;
        endcase
    end

    always_comb begin
        wr_1    = 1'b0;
        wr_2    = 1'b0;
        wdata_1 = i_data;
        wdata_2 = i_data;
        case (state)
            FILL_1: wr_1 = accept & ~is_zero;
            FILL_2: wr_2 = accept & ~is_zero;
            TERM_1: begin
                wr_1    = ~full_1;
                wdata_1 = TERM;
            end
            TERM_2: begin
                wr_2    = ~full_2;
                wdata_2 = TERM;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= FILL_1;
            run_cnt   <= '0;
            last_pend <= 1'b0;
            active    <= 1'b0;
            err       <= 1'b0;
        end else begin
            active <= 1'b1;
            err    <= err | (accept & is_zero) | rd_err_1 | rd_err_2;
            case (state)
                FILL_1: begin
                    if (run_end) begin
                        state     <= TERM_1;
                        run_cnt   <= '0;
                        last_pend <= i_last;
                    end else if (accept && !is_zero) begin
                        run_cnt <= run_cnt + CW'(1);
                    end
                end
                FILL_2: begin
                    if (run_end) begin
                        state   <= TERM_2;
                        run_cnt <= '0;
                    end else if (accept && !is_zero) begin
                        run_cnt <= run_cnt + CW'(1);
                    end
                end
                TERM_1: begin
                    // Stream ended in lane 1: give lane 2 a bare terminator so
                    // the merger sees both inputs close.
                    if (!full_1) state <= last_pend ? TERM_2 : FILL_2;
                end
                TERM_2: begin
                    if (!full_2) begin
                        state     <= FILL_1;
                        last_pend <= 1'b0;
                    end
                end
                default: state <= FILL_1;
            endcase
        end
    end

    assign o_err = err;

    merger_lane_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_lane_1 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_wr     (wr_1),
        .i_wdata  (wdata_1),
        .i_rd     (i_fifo_1_read),
        .o_rdata  (o_fifo_1),
        .o_empty  (o_fifo_1_empty),
        .o_full   (full_1),
        .o_rd_err (rd_err_1)
    );

    merger_lane_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_lane_2 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_wr     (wr_2),
        .i_wdata  (wdata_2),
        .i_rd     (i_fifo_2_read),
        .o_rdata  (o_fifo_2),
        .o_empty  (o_fifo_2_empty),
        .o_full   (full_2),
        .o_rd_err (rd_err_2)
    );

endmodule
